// File: rtl/note_detector.sv
// Tone classifier: measures speaker_in half-periods and reports the matching note one-hot.
// Optional macro NOTE_DET_GLITCH_FILTER_EN drops edges arriving less than MIN_HALF cycles apart.
module note_detector #(
  parameter int HP0      = 95420,
  parameter int HP1      = 85034,
  parameter int HP2      = 75758,
  parameter int HP3      = 71633,
  parameter int HP4      = 63776,
  parameter int HP5      = 56818,
  parameter int HP6      = 50607,
  parameter int HP7      = 47801,
  parameter int TOL      = 500,
  parameter int STABLE_N = 4,
  parameter int MIN_HALF = 1000,
  parameter int CNT_W    = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       speaker_in,
  output logic [7:0] note_onehot,
  output logic       note_valid,
  output logic       silent
);

  localparam int HP [8] = '{HP0, HP1, HP2, HP3, HP4, HP5, HP6, HP7};
  localparam int SW = $clog2(STABLE_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef NOTE_DET_GLITCH_FILTER_EN
  localparam bit GF_EN = 1'b1;
`else
  localparam bit GF_EN = 1'b0;
`endif
  localparam int GLITCH_MIN = GF_EN ? MIN_HALF : 0;

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_sync;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_cls;
  logic [SW-1:0]    r_stab;
  logic             r_cls_vld;
  logic             w_edge, w_edge_acc, w_sat, w_sample, w_timeout;
  logic [7:0]       w_cls;
  logic [SW-1:0]    w_stab_nxt;

  assign w_edge     = r_sync[1] ^ r_prev;
  assign w_sat      = (r_cnt == CNT_MAX);
  // With the filter off GLITCH_MIN is 0, so every edge is accepted.
  assign w_edge_acc = w_edge && (int'(r_cnt) >= GLITCH_MIN);

  always_comb begin
    w_state_nxt = r_state;
    w_sample    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: if (w_edge_acc) w_state_nxt = MEASURE;
      MEASURE: begin
        if (w_edge_acc) begin
          w_sample = 1'b1;
        end else if (w_sat) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Descending scan so the lowest matching note wins on overlap.
  always_comb begin
    w_cls = '0;
    for (int k = 7; k >= 0; k--) begin
      if ((int'(r_cnt) >= HP[k] - TOL) && (int'(r_cnt) <= HP[k] + TOL)) begin
        w_cls    = '0;
        w_cls[k] = 1'b1;
      end
    end
  end

  always_comb begin
    w_stab_nxt = SW'(1);
    if (w_cls == r_cls)
      w_stab_nxt = (r_stab == SW'(STABLE_N)) ? r_stab : r_stab + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync      <= '0;
      r_prev      <= 1'b0;
      r_cnt       <= '0;
      r_state     <= IDLE;
      r_cls       <= '0;
      r_stab      <= '0;
      r_cls_vld   <= 1'b0;
      note_onehot <= '0;
      note_valid  <= 1'b0;
      silent      <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], speaker_in};
      r_prev    <= r_sync[1];
      r_state   <= w_state_nxt;
      r_cls_vld <= w_sample;
      note_valid <= 1'b0;

      if (w_edge_acc)  r_cnt <= CNT_W'(1);
      else if (!w_sat) r_cnt <= r_cnt + CNT_W'(1);

      if (w_sample) begin
        r_cls  <= w_cls;
        r_stab <= w_stab_nxt;
      end else if (w_timeout) begin
        r_cls  <= '0;
        r_stab <= '0;
      end

      // Silence bypasses the stability filter.
      if (w_timeout) begin
        note_onehot <= '0;
        note_valid  <= |note_onehot;
        silent      <= 1'b1;
      end else if (r_cls_vld && (r_stab == SW'(STABLE_N)) && (r_cls != note_onehot)) begin
        note_onehot <= r_cls;
        note_valid  <= 1'b1;
      end

      if (r_state == IDLE && w_edge_acc) silent <= 1'b0;
    end
  end

endmodule

// File: tb/tb_note_detector.sv
// Randomised and directed bench for note_detector against a timestamped event model.
module tb_note_detector;
  localparam int HP [8] = '{380, 340, 300, 286, 256, 226, 202, 190};
  localparam int TOL  = 4;
  localparam int SN   = 4;
  localparam int CW   = 12;
  localparam int MAXC = (1 << CW) - 1;

  logic       clk = 1'b0, rst_n = 1'b1, spk = 1'b0;
  logic [7:0] note_onehot;
  logic       note_valid, silent;

  note_detector #(
    .HP0(HP[0]), .HP1(HP[1]), .HP2(HP[2]), .HP3(HP[3]),
    .HP4(HP[4]), .HP5(HP[5]), .HP6(HP[6]), .HP7(HP[7]),
    .TOL(TOL), .STABLE_N(SN), .MIN_HALF(50), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .speaker_in(spk),
    .note_onehot(note_onehot), .note_valid(note_valid), .silent(silent)
  );

  always #5 clk = ~clk;

  int cyc = 0, nchk = 0, nerr = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      if (nerr <= 30) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] classify(input int s);
    logic [7:0] one = 8'h01;
    for (int k = 0; k < 8; k++)
      if ((s - HP[k] <= TOL) && (HP[k] - s <= TOL)) return one << k;
    return 8'h00;
  endfunction

  // Model: input edges are seen at the posedge that samples them; output changes are
  // scheduled by absolute cycle number (silent +2, note/valid +3, timeout +2+MAXC).
  logic       m_lvl = 1'b0, m_meas = 1'b0;
  int         m_plast = 0, m_cnt = 0;
  logic [7:0] m_note = 8'h00, m_prev = 8'h00;
  logic [7:0] ev_note [int];
  logic       ev_sil [int];
  bit         ev_pulse [int];

  always @(posedge clk) begin : model
    logic       edge_now;
    logic [7:0] c;
    cyc++;
    if (!rst_n) begin
      m_lvl = 1'b0; m_meas = 1'b0; m_note = 8'h00; m_prev = 8'h00; m_cnt = 0;
      ev_note.delete(); ev_sil.delete(); ev_pulse.delete();
    end else begin
      edge_now = (spk != m_lvl);
      m_lvl = spk;
      if (m_meas && !edge_now && (cyc - m_plast == MAXC)) begin
        m_meas = 1'b0;
        ev_sil[cyc+2]  = 1'b1;
        ev_note[cyc+2] = 8'h00;
        if (m_note != 8'h00) ev_pulse[cyc+2] = 1'b1;
        m_note = 8'h00; m_prev = 8'h00; m_cnt = 0;
      end
      if (edge_now) begin
        if (!m_meas) begin
          m_meas = 1'b1;
          ev_sil[cyc+2] = 1'b0;
        end else begin
          c = classify(cyc - m_plast);
          m_cnt = (c == m_prev) ? ((m_cnt < SN) ? m_cnt + 1 : SN) : 1;
          m_prev = c;
          if (m_cnt == SN && c != m_note) begin
            m_note = c;
            ev_note[cyc+3]  = c;
            ev_pulse[cyc+3] = 1'b1;
          end
        end
        m_plast = cyc;
      end
    end
  end

  logic [7:0] e_note = 8'h00;
  logic       e_sil = 1'b1;
  int         npulse = 0;
  logic [7:0] pq [$];

  always @(negedge clk) begin : compare
    logic e_val;
    if (cyc > 0) begin
      if (!rst_n) begin
        e_note = 8'h00; e_sil = 1'b1; e_val = 1'b0;
      end else begin
        if (ev_note.exists(cyc)) e_note = ev_note[cyc];
        if (ev_sil.exists(cyc))  e_sil  = ev_sil[cyc];
        e_val = (ev_pulse.exists(cyc) != 0);
      end
      chk("note_onehot", int'(note_onehot), int'(e_note));
      chk("note_valid",  int'(note_valid),  int'(e_val));
      chk("silent",      int'(silent),      int'(e_sil));
      if (rst_n && note_valid) begin
        npulse++;
        pq.push_back(note_onehot);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic tone(input int hp, input int n);
    repeat (n) begin
      tick(hp);
      spk = ~spk;
    end
  endtask

  initial begin
    int k, d;
    #1 rst_n = 1'b0;
    tick(3);
    chk("rst_note", int'(note_onehot), 0);
    chk("rst_valid", int'(note_valid), 0);
    chk("rst_silent", int'(silent), 1);
    rst_n = 1'b1;
    tick(5);

    // A4-like tone: one pulse after the 5th edge
    npulse = 0;
    tone(HP[5], 4);
    chk("a4_no_early_pulse", npulse, 0);
    chk("a4_silent_low", int'(silent), 0);
    tone(HP[5], 1);
    tick(5);
    chk("a4_pulse", npulse, 1);
    chk("a4_note", int'(note_onehot), 32'h20);
    tick(HP[5] - 5);
    spk = ~spk;
    tone(HP[5], 4);
    chk("a4_single_pulse", npulse, 1);

    // Sweep of all notes
    npulse = 0;
    pq.delete();
    for (int i = 0; i < 8; i++) tone(HP[i], 10);
    tick(5);
    chk("sweep_pulses", npulse, 8);
    for (int i = 0; i < 8; i++)
      chk("sweep_seq", (i < pq.size()) ? int'(pq[i]) : -1, 1 << i);

    // Lowest note then silence until timeout
    tone(HP[0], 6);
    tick(5);
    chk("low_note", int'(note_onehot), 32'h01);
    npulse = 0;
    tick(MAXC - 20);
    chk("pre_timeout_silent", int'(silent), 0);
    chk("pre_timeout_note", int'(note_onehot), 32'h01);
    tick(40);
    chk("timeout_silent", int'(silent), 1);
    chk("timeout_note", int'(note_onehot), 0);
    chk("timeout_pulse", npulse, 1);

    // One cycle outside tolerance never qualifies; exactly at tolerance does
    npulse = 0;
    tone(HP[5] + TOL + 1, 8);
    tick(5);
    chk("offtol_note", int'(note_onehot), 0);
    chk("offtol_pulses", npulse, 0);
    chk("offtol_silent", int'(silent), 0);
    tick(HP[5] + TOL - 5);
    spk = ~spk;
    tone(HP[5] + TOL, 5);
    tick(5);
    chk("attol_note", int'(note_onehot), 32'h20);
    chk("attol_pulses", npulse, 1);

    // Top note with a 20-cycle glitch inside one half-period
    tone(HP[7], 8);
    tick(5);
    chk("top_note", int'(note_onehot), 32'h80);
    npulse = 0;
    tick(90); spk = ~spk;
    tick(20); spk = ~spk;
    tick(HP[7] - 115); spk = ~spk;
    tone(HP[7], 9);
    tick(5);
    chk("glitch_note", int'(note_onehot), 32'h80);
    chk("glitch_pulses", npulse, 0);

    // Reset in the middle of a half-period
    tone(HP[5], 8);
    tick(60);
    rst_n = 1'b0;
    #1;
    chk("async_rst_note", int'(note_onehot), 0);
    chk("async_rst_valid", int'(note_valid), 0);
    chk("async_rst_silent", int'(silent), 1);
    tick(3);
    rst_n = 1'b1;
    npulse = 0;
    tone(HP[5], 4);
    chk("redetect_early", npulse, 0);
    tone(HP[5], 1);
    tick(5);
    chk("redetect_pulse", npulse, 1);
    chk("redetect_note", int'(note_onehot), 32'h20);
    chk("redetect_silent", int'(silent), 0);
    tick(HP[5] - 5);
    spk = ~spk;

    // Random tones with jitter around tolerance, short bursts and one silence gap
    for (int s = 0; s < 12; s++) begin
      if (s == 6) tick(MAXC + 100);
      if ($urandom_range(0, 4) == 0) begin
        tone(int'($urandom_range(15, 60)), 2);
      end else begin
        k = int'($urandom_range(0, 7));
        d = int'($urandom_range(0, 2 * TOL + 4)) - (TOL + 2);
        tone(HP[k] + d, int'($urandom_range(2, 7)));
      end
    end
    tick(10);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
